// File: rtl/dual_port_ram_14x8.sv
// rtl/dual_port_ram_14x8.sv - simple dual-port synchronous RAM, one write port and one registered read port
//
// Ports:
//   clock      single clock; storage and q update on its rising edge
//   reset_n    asynchronous active-low reset; clears q, inhibits reads and writes
//   data       write data
//   wraddress  write address
//   wren       write enable, active high
//   rdaddress  read address
//   rden       read enable, active high; q holds while low
//   q          registered read data, one-cycle latency

module dual_port_ram_14x8 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 14,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] wraddress,
  input  logic                  wren,
  input  logic [ADDR_WIDTH-1:0] rdaddress,
  input  logic                  rden,
  output logic [DATA_WIDTH-1:0] q
);

  // Contents start at zero on power-up; reset never touches the array.
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1] = '{default: '0};

  logic wr_in_range;
  logic rd_in_range;

  // Range checks only exist when the array is smaller than the address space;
  // otherwise every address maps 1:1 onto a word.
  generate
    if (DEPTH < 2 ** ADDR_WIDTH) begin : g_partial
      localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
      assign wr_in_range = (wraddress <= LAST);
      assign rd_in_range = (rdaddress <= LAST);
    end else begin : g_full
      assign wr_in_range = 1'b1;
      assign rd_in_range = 1'b1;
    end
  endgenerate

  // Write port. reset_n is sampled as a level so an edge during reset stores
  // nothing, while the array itself stays out of the reset network.
  always_ff @(posedge clock) begin
    if (reset_n && wren && wr_in_range) begin
      mem[wraddress] <= data;
    end
  end

  // Read port. The non-blocking write above means a same-address read on the
  // same edge sees the word as it was before this write (old data).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (rden) begin
      if (rd_in_range) begin
        q <= mem[rdaddress];
      end else begin
        q <= '0;
      end
    end
  end

  // X on an enable outside reset is a caller bug with no defined recovery.
  a_enables_known : assert property (
    @(posedge clock) disable iff (!reset_n) !$isunknown({wren, rden})
  ) else $error("unknown value on wren/rden");

endmodule

// File: tb/tb_dual_port_ram_14x8.sv
// tb/tb_dual_port_ram_14x8.sv - directed self-checking bench for dual_port_ram_14x8

module tb_dual_port_ram_14x8;

  logic        clock;
  logic        reset_n;
  logic [7:0]  data;
  logic [13:0] wraddress;
  logic        wren;
  logic [13:0] rdaddress;
  logic        rden;
  logic [7:0]  q;

  int n_cmp;
  int n_err;

  dual_port_ram_14x8 dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .data      (data),
    .wraddress (wraddress),
    .wren      (wren),
    .rdaddress (rdaddress),
    .rden      (rden),
    .q         (q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [13:0] a, input logic [7:0] d);
    wren = 1'b1; wraddress = a; data = d; rden = 1'b0;
    tick();
    wren = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [13:0] a, input logic [7:0] exp);
    rden = 1'b1; rdaddress = a;
    tick();
    check(tag, q, exp);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n   = 1'b0;
    wren      = 1'b1;
    wraddress = 14'd3;
    data      = 8'h5A;
    rden      = 1'b1;
    rdaddress = 14'd3;

    #1;
    check("reset_t0", q, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", q, 8'h00);
    end

    reset_n = 1'b1;
    wren    = 1'b0;
    rd("reset_write_inhibited", 14'd3, 8'h00);

    wr(14'd0, 8'h11);
    wr(14'd1, 8'h22);
    wr(14'd2, 8'h33);
    rd("basic_a0", 14'd0, 8'h11);
    rd("basic_a1", 14'd1, 8'h22);
    rd("basic_a2", 14'd2, 8'h33);

    wr(14'd7, 8'h40);
    wren = 1'b1; wraddress = 14'd7; data = 8'hC3;
    rden = 1'b1; rdaddress = 14'd7;
    tick();
    wren = 1'b0;
    check("rdw_old_data", q, 8'h40);
    rd("rdw_new_data", 14'd7, 8'hC3);

    wren = 1'b1; wraddress = 14'd5; data = 8'h77;
    rden = 1'b1; rdaddress = 14'd2;
    tick();
    wren = 1'b0;
    check("rdw_diff_addr_read", q, 8'h33);
    rd("rdw_diff_addr_write", 14'd5, 8'h77);

    rd("hold_load", 14'd1, 8'h22);
    rden = 1'b0; rdaddress = 14'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_rden0", q, 8'h22);
    end

    wr(14'd16383, 8'hFF);
    wr(14'd0, 8'h01);
    rd("ext_top", 14'd16383, 8'hFF);
    rd("ext_bottom", 14'd0, 8'h01);
    rd("ext_unwritten", 14'd8000, 8'h00);

    rd("async_pre", 14'd2, 8'h33);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_clear_no_edge", q, 8'h00);
    wren = 1'b1; wraddress = 14'd2; data = 8'hAA;
    tick();
    check("async_hold", q, 8'h00);
    wren    = 1'b0;
    reset_n = 1'b1;
    rd("async_contents_kept", 14'd2, 8'h33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
